robo_ambiente: RTL and testbench
================================

// Module: robo_ambiente
// PURPOSE
//  Synthesisable environment/odometry stage in the loop with the Robo wall-follower FSM.
//  Reads a 20x20 map ROM and keeps the robot pose (row, column, orientation).
//  Drives the Robo head/left sensor inputs, consumes its avancar/girar outputs and counts moves.
//  Flags illegal poses: off the map or inside a wall.
// PARAMETERS
//  START_ROW  5'd1   start row, 1..20
//  START_COL  5'd1   start column, 1..20
//  START_DIR  2'b00  start orientation (N=00 S=01 L=10 O=11)
// PORTS
//  clock            in   1   single clock, rising edge
//  reset            in   1   synchronous, active-high
//  start            in   1   1-cycle pulse; begins a run
//  qtd_movimentos   in   8   move budget, latched when start is accepted
//  map_addr         out  5   map row address, 1..20 (0 is never driven after reset)
//  map_data         in   20  asynchronous ROM row; column c is map_data[20-c]; 1 = wall
//  avancar          in   1   from Robo: advance one cell
//  girar            in   1   from Robo: turn left 90 degrees
//  head             out  1   wall or border directly ahead
//  left             out  1   wall or border on robot's left
//  sensores_validos out  1   high for exactly 1 cycle (PRESENT); Robo step enable
//  linha            out  5   current row
//  coluna           out  5   current column
//  orientacao       out  2   current orientation
//  movimentos       out  8   moves completed in this run
//  fim              out  1   budget exhausted, sticky
//  erro             out  1   anomaly, sticky until reset
// BEHAVIOUR
//  Reset: outputs take their reset values on the next edge; applies from any state, including mid-move.
//    - state=IDLE, pose=START_*, movimentos=0.
//    - head, left, sensores_validos, fim, erro, map_addr all 0.
//  FSM states: IDLE, CHECK, FETCH_H, FETCH_L, PRESENT, APPLY, DONE, ERROR.
//  - IDLE: start=1 -> latch qtd, movimentos=0, go to CHECK.
//  - DONE: start=1 -> latch qtd, movimentos=0, fim=0, go to CHECK; pose is kept.
//  - ERROR: start is ignored.
//  - CHECK: map_addr=linha.
//      * Pose outside 1..20, or own cell =1 -> erro=1, go to ERROR.
//      * Else movimentos==qtd -> fim=1, go to DONE.
//      * Else go to FETCH_H.
//  - FETCH_H: map_addr = row of the cell ahead; capture head_nxt.
//      * N: (r-1,c)   S: (r+1,c)   L: (r,c+1)   O: (r,c-1)
//      * If that cell is off the map: head_nxt=1 and map_data is ignored.
//  - FETCH_L: map_addr = row of the left cell; capture left_nxt with the same border rule.
//      * N: (r,c-1)   S: (r,c+1)   L: (r-1,c)   O: (r+1,c)
//  - PRESENT: head/left <= head_nxt/left_nxt; sensores_validos=1.
//      * head and left are held unchanged until the next PRESENT.
//  - APPLY: sample avancar/girar at the edge ending APPLY; movimentos+1; go to CHECK.
//      * avancar has priority over girar.
//      * avancar: N r-1, S r+1, L c+1, O c-1.
//      * girar (avancar=0): N->O, O->S, S->L, L->N.
//      * Neither asserted: pose unchanged, but the move is still counted.
//  - Row/column arithmetic is 5-bit unsigned, with no clamping.
//      * A step past row/col 1 wraps to 0 (underflow gives 31).
//      * CHECK must report that pose as erro; it is never silently corrected.
//  Timing: 5 cycles per move (CHECK..APPLY).
//    - First sensores_validos pulse: 4 cycles after start is accepted.
//    - fim rises 1 cycle after the final APPLY.
//  qtd_movimentos=0: CHECK goes straight to DONE (the start cell is still checked).
// STRUCTURE
//  Package robo_pkg: orientation codes N/S/L/O, FSM state enum, ROWS=20, COLS=20.
//  Sub-module robo_vizinhos (combinational).
//    - Inputs: pose. Outputs: head/left cell coordinates and their off-map flags.
//    - Also used for the next-pose computation in APPLY.
// TESTING
//  T1 reset: after reset, START=(3,4,S) -> linha=3, coluna=4, orientacao=01, movimentos=0; fim=erro=head=left=0.
//  T2 advance: empty map, (10,10,N), qtd=1, avancar=1 in APPLY
//     -> linha=9, movimentos=1, fim=1 exactly 6 cycles after start.
//  T3 turns: empty map, (10,10,N), qtd=4, girar=1 every step
//     -> orientacao sequence 11,01,10,00; linha=coluna=10.
//  T4 borders: empty map, (1,1,N) -> head=1, left=1 at PRESENT; (20,20,S) -> head=1, left=1.
//  T5 wall: wall at (9,10), (10,10,N) -> head=1.
//     Force avancar=1 -> next CHECK sets erro=1; fim stays 0; start is ignored afterwards.
//  T6 reset mid-run: assert reset during APPLY of move 2
//     -> next edge shows START pose, movimentos=0, sensores_validos=0, state IDLE.

Source files
------------

// File: rtl/robo_pkg.sv
// Shared types and helpers for the Robo environment stage: orientation codes,
// FSM states, map geometry and map-row decoding.
package robo_pkg;

  localparam int ROWS = 20;
  localparam int COLS = 20;

  typedef enum logic [1:0] {
    DIR_N = 2'b00,
    DIR_S = 2'b01,
    DIR_L = 2'b10,
    DIR_O = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH_H,
    FETCH_L,
    PRESENT,
    APPLY,
    DONE,
    ERROR
  } state_t;

  function automatic logic on_map_row(logic [4:0] v);
    return (v >= 5'd1) && (v <= 5'(ROWS));
  endfunction

  function automatic logic on_map_col(logic [4:0] v);
    return (v >= 5'd1) && (v <= 5'(COLS));
  endfunction

  // Column c lives at bit COLS-c; any column outside 1..COLS reads as wall.
  function automatic logic cell_bit(logic [COLS-1:0] row, logic [4:0] col);
    logic b;
    b = 1'b1;
    for (int i = 1; i <= COLS; i++) begin
      if (col == 5'(i)) b = row[COLS-i];
    end
    return b;
  endfunction

  function automatic dir_t turn_left(dir_t d);
    dir_t n;
    case (d)
      DIR_N:   n = DIR_O;
      DIR_O:   n = DIR_S;
      DIR_S:   n = DIR_L;
      default: n = DIR_N;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/robo_vizinhos.sv
// Combinational neighbour finder: coordinates of the cell ahead and the cell on the
// robot's left, with off-map flags. 5-bit arithmetic wraps on purpose.
module robo_vizinhos
  import robo_pkg::*;
(
  input  logic [4:0] linha,
  input  logic [4:0] coluna,
  input  dir_t       orientacao,
  output logic [4:0] frente_linha,
  output logic [4:0] frente_coluna,
  output logic       frente_fora,
  output logic [4:0] esq_linha,
  output logic [4:0] esq_coluna,
  output logic       esq_fora
);

  always_comb begin
    frente_linha  = linha;
    frente_coluna = coluna;
    esq_linha     = linha;
    esq_coluna    = coluna;
    case (orientacao)
      DIR_N: begin
        frente_linha = linha - 5'd1;
        esq_coluna   = coluna - 5'd1;
      end
      DIR_S: begin
        frente_linha = linha + 5'd1;
        esq_coluna   = coluna + 5'd1;
      end
      DIR_L: begin
        frente_coluna = coluna + 5'd1;
        esq_linha     = linha - 5'd1;
      end
      default: begin
        frente_coluna = coluna - 5'd1;
        esq_linha     = linha + 5'd1;
      end
    endcase
  end

  assign frente_fora = !(on_map_row(frente_linha) && on_map_col(frente_coluna));
  assign esq_fora    = !(on_map_row(esq_linha) && on_map_col(esq_coluna));

endmodule

// File: rtl/robo_ambiente.sv
// Environment/odometry stage for the Robo wall follower: reads the map ROM, senses
// head/left walls, applies the Robo's moves to the pose and flags illegal poses.
module robo_ambiente
  import robo_pkg::*;
#(
  parameter logic [4:0] START_ROW = 5'd1,
  parameter logic [4:0] START_COL = 5'd1,
  parameter logic [1:0] START_DIR = 2'b00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  qtd_movimentos,
  output logic [4:0]  map_addr,
  input  logic [19:0] map_data,
  input  logic        avancar,
  input  logic        girar,
  output logic        head,
  output logic        left,
  output logic        sensores_validos,
  output logic [4:0]  linha,
  output logic [4:0]  coluna,
  output logic [1:0]  orientacao,
  output logic [7:0]  movimentos,
  output logic        fim,
  output logic        erro
);

  state_t     state, state_nxt;
  dir_t       dir_q;
  logic [7:0] qtd_q;
  logic       head_nxt, left_nxt;
  logic       fim_q;
  logic [4:0] addr_q, addr_now;
  logic [4:0] frente_linha, frente_coluna, esq_linha, esq_coluna;
  logic       frente_fora, esq_fora;
  logic       pose_invalida, budget_done;

  robo_vizinhos u_vizinhos (
    .linha         (linha),
    .coluna        (coluna),
    .orientacao    (dir_q),
    .frente_linha  (frente_linha),
    .frente_coluna (frente_coluna),
    .frente_fora   (frente_fora),
    .esq_linha     (esq_linha),
    .esq_coluna    (esq_coluna),
    .esq_fora      (esq_fora)
  );

  // Only meaningful in CHECK, where the ROM is addressed with the current row.
  assign pose_invalida = !on_map_row(linha) || !on_map_col(coluna) || cell_bit(map_data, coluna);
  assign budget_done   = (movimentos == qtd_q);
  assign left_nxt      = esq_fora | cell_bit(map_data, esq_coluna);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = CHECK;
      CHECK: begin
        if (pose_invalida)    state_nxt = ERROR;
        else if (budget_done) state_nxt = DONE;
        else                  state_nxt = FETCH_H;
      end
      FETCH_H: state_nxt = FETCH_L;
      FETCH_L: state_nxt = PRESENT;
      PRESENT: state_nxt = APPLY;
      APPLY:   state_nxt = CHECK;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = IDLE;
    endcase
  end

  // Off-map neighbour rows fall back to a legal row so address 0 never reaches the ROM.
  always_comb begin
    addr_now = addr_q;
    case (state)
      CHECK:   addr_now = on_map_row(linha) ? linha : 5'd1;
      FETCH_H: addr_now = on_map_row(frente_linha) ? frente_linha : linha;
      FETCH_L: addr_now = on_map_row(esq_linha) ? esq_linha : linha;
      default: addr_now = addr_q;
    endcase
  end

  assign map_addr         = addr_now;
  assign orientacao       = dir_q;
  assign sensores_validos = (state == PRESENT);
  assign fim              = fim_q | ((state == CHECK) && !pose_invalida && budget_done);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      linha      <= START_ROW;
      coluna     <= START_COL;
      dir_q      <= dir_t'(START_DIR);
      movimentos <= 8'd0;
      qtd_q      <= 8'd0;
      head       <= 1'b0;
      left       <= 1'b0;
      head_nxt   <= 1'b0;
      fim_q      <= 1'b0;
      erro       <= 1'b0;
      addr_q     <= 5'd0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_now;
      case (state)
        IDLE: begin
          if (start) begin
            qtd_q      <= qtd_movimentos;
            movimentos <= 8'd0;
          end
        end
        DONE: begin
          if (start) begin
            qtd_q      <= qtd_movimentos;
            movimentos <= 8'd0;
            fim_q      <= 1'b0;
          end
        end
        CHECK: begin
          if (pose_invalida)    erro  <= 1'b1;
          else if (budget_done) fim_q <= 1'b1;
        end
        FETCH_H: head_nxt <= frente_fora | cell_bit(map_data, frente_coluna);
        // Sensors are loaded here so they are valid together with sensores_validos.
        FETCH_L: begin
          head <= head_nxt;
          left <= left_nxt;
        end
        APPLY: begin
          movimentos <= movimentos + 8'd1;
          if (avancar) begin
            linha  <= frente_linha;
            coluna <= frente_coluna;
          end else if (girar) begin
            dir_q <= turn_left(dir_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_robo_ambiente.sv
// Self-checking bench for robo_ambiente: pose/timing reference model plus
// directed navigation scenarios and randomized runs on random maps.
module tb_robo_ambiente;

  localparam int SR = 3;
  localparam int SC = 4;
  localparam int SD = 1;

  logic        clock, reset, start;
  logic [7:0]  qtd_movimentos;
  logic [4:0]  map_addr;
  logic [19:0] map_data;
  logic        avancar, girar;
  logic        head, left, sensores_validos;
  logic [4:0]  linha, coluna;
  logic [1:0]  orientacao;
  logic [7:0]  movimentos;
  logic        fim, erro;

  robo_ambiente #(
    .START_ROW (5'd3),
    .START_COL (5'd4),
    .START_DIR (2'b01)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .qtd_movimentos   (qtd_movimentos),
    .map_addr         (map_addr),
    .map_data         (map_data),
    .avancar          (avancar),
    .girar            (girar),
    .head             (head),
    .left             (left),
    .sensores_validos (sensores_validos),
    .linha            (linha),
    .coluna           (coluna),
    .orientacao       (orientacao),
    .movimentos       (movimentos),
    .fim              (fim),
    .erro             (erro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bit map_bits [1:20][1:20];

  // ROM: column c of a row appears at bit 20-c.
  always_comb begin
    int ra;
    ra = int'(map_addr);
    map_data = '0;
    if (ra >= 1 && ra <= 20)
      for (int c = 1; c <= 20; c++) map_data[20-c] = map_bits[ra][c];
  end

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_r = SR, m_c = SC, m_d = SD, m_mov = 0, m_qtd = 0, m_cyc = 0;
  bit m_run = 0, m_fim = 0, m_erro = 0, m_head = 0, m_left = 0;

  function automatic bit wall(int r, int c);
    if (r < 1 || r > 20 || c < 1 || c > 20) return 1'b1;
    return map_bits[r][c];
  endfunction

  function automatic int turn(int d);
    case (d)
      0: return 3;
      3: return 1;
      1: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int d_row(int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction

  function automatic int d_col(int d);
    return (d == 2) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  // A move spans five cycles after start: check, ahead fetch, left fetch, present, apply.
  initial forever begin
    int p;
    @(posedge clock);
    if (reset) begin
      m_run = 0; m_cyc = 0; m_r = SR; m_c = SC; m_d = SD; m_mov = 0; m_qtd = 0;
      m_fim = 0; m_erro = 0; m_head = 0; m_left = 0;
    end else if (!m_erro) begin
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_cyc = 1; m_mov = 0; m_qtd = int'(qtd_movimentos); m_fim = 0;
        end
      end else begin
        p = (m_cyc - 1) % 5;
        if (p == 0) begin
          if (wall(m_r, m_c)) begin m_erro = 1; m_run = 0; end
          else if (m_mov == m_qtd) begin m_fim = 1; m_run = 0; end
        end else if (p == 2) begin
          m_head = wall((m_r + d_row(m_d)) & 31, (m_c + d_col(m_d)) & 31);
          m_left = wall((m_r + d_row(turn(m_d))) & 31, (m_c + d_col(turn(m_d))) & 31);
        end else if (p == 4) begin
          if (avancar) begin
            m_r = (m_r + d_row(m_d)) & 31;
            m_c = (m_c + d_col(m_d)) & 31;
          end else if (girar) begin
            m_d = turn(m_d);
          end
          m_mov = (m_mov + 1) & 255;
        end
        m_cyc++;
      end
    end
  end

  // ---------------- compare process ----------------
  bit sv_head, sv_left;
  int prev_mov = 0;
  int orient_log[$];

  initial forever begin
    int p;
    bit exp_fim;
    @(negedge clock);
    p = m_run ? (m_cyc - 1) % 5 : -1;
    exp_fim = m_fim || (p == 0 && !wall(m_r, m_c) && m_mov == m_qtd);
    checkOutput("linha", int'(linha), m_r);
    checkOutput("coluna", int'(coluna), m_c);
    checkOutput("orientacao", int'(orientacao), m_d);
    checkOutput("movimentos", int'(movimentos), m_mov);
    checkOutput("erro", int'(erro), int'(m_erro));
    checkOutput("fim", int'(fim), int'(exp_fim));
    checkOutput("sensores_validos", int'(sensores_validos), int'(p == 3));
    checkOutput("head", int'(head), int'(m_head));
    checkOutput("left", int'(left), int'(m_left));
    if (p == 0 && m_r >= 1 && m_r <= 20) checkOutput("map_addr", int'(map_addr), m_r);
    if (sensores_validos) begin sv_head = head; sv_left = left; end
    if (int'(movimentos) != prev_mov && movimentos != 8'd0) orient_log.push_back(int'(orientacao));
    prev_mov = int'(movimentos);
  end

  // ---------------- Robo stand-in ----------------
  string script = "";
  int sidx = 0;

  // Scripted command is set during PRESENT and held through APPLY; otherwise noise.
  initial begin
    bit keep;
    byte ch;
    keep = 0; avancar = 0; girar = 0;
    forever begin
      @(negedge clock);
      if (sensores_validos && script.len() > 0) begin
        ch = (sidx < script.len()) ? script[sidx] : 8'd45;
        sidx++;
        avancar = (ch == "A") || (ch == "B");
        girar   = (ch == "G") || (ch == "B");
        keep = 1;
      end else if (keep) begin
        keep = 0;
      end else begin
        avancar = 1'($urandom_range(0, 1));
        girar   = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input int q);
    start = 1'b1;
    qtd_movimentos = 8'(q);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitIdle(input bit mid_starts);
    int n;
    n = 0;
    while (m_run && n < 3000) begin
      @(negedge clock);
      start = 1'b0;
      n++;
      if (mid_starts && m_run && ((m_cyc - 1) % 5) inside {[1:3]} && $urandom_range(0, 7) == 0)
        start = 1'b1;
    end
    start = 1'b0;
    total++;
    if (m_run) begin
      bad++;
      $display("[TB] FAIL run_timeout: still running=%0d expected 0", m_run);
    end
  endtask

  task automatic runScript(input string s, input int q);
    script = s;
    sidx = 0;
    applyStimulus(q);
    waitIdle(1'b0);
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic string rep(input string ch, input int n);
    string s;
    s = "";
    for (int i = 0; i < n; i++) s = {s, ch};
    return s;
  endfunction

  function automatic string nav(input string s);
    return s;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    string s;
    reset = 1'b1; start = 1'b0; qtd_movimentos = 8'd0;
    for (int r = 1; r <= 20; r++) for (int c = 1; c <= 20; c++) map_bits[r][c] = 0;
    repeat (2) @(negedge clock);

    $display("[TB] reset values");
    checkOutput("t1_linha", int'(linha), 3);
    checkOutput("t1_coluna", int'(coluna), 4);
    checkOutput("t1_orientacao", int'(orientacao), 1);
    checkOutput("t1_movimentos", int'(movimentos), 0);
    checkOutput("t1_fim", int'(fim), 0);
    checkOutput("t1_erro", int'(erro), 0);
    checkOutput("t1_head", int'(head), 0);
    checkOutput("t1_left", int'(left), 0);
    checkOutput("t1_map_addr", int'(map_addr), 0);
    reset = 1'b0;

    $display("[TB] navigate to (10,10,N)");
    s = {rep("A", 7), "G", rep("A", 6), "G"};
    runScript(s, s.len());
    checkOutput("nav1_linha", int'(linha), 10);
    checkOutput("nav1_coluna", int'(coluna), 10);
    checkOutput("nav1_orient", int'(orientacao), 0);
    checkOutput("nav1_fim", int'(fim), 1);

    $display("[TB] single advance timing");
    script = "A"; sidx = 0;
    applyStimulus(1);
    repeat (3) @(negedge clock);
    checkOutput("t2_sv_cycle4", int'(sensores_validos), 1);
    @(negedge clock);
    checkOutput("t2_fim_cycle5", int'(fim), 0);
    @(negedge clock);
    checkOutput("t2_fim_cycle6", int'(fim), 1);
    checkOutput("t2_linha", int'(linha), 9);
    checkOutput("t2_movimentos", int'(movimentos), 1);
    waitIdle(1'b0);

    $display("[TB] four left turns");
    runScript("GGAGG", 5);
    orient_log.delete();
    runScript("GGGG", 4);
    checkOutput("t3_log_size", orient_log.size(), 4);
    if (orient_log.size() == 4) begin
      checkOutput("t3_turn1", orient_log[0], 3);
      checkOutput("t3_turn2", orient_log[1], 1);
      checkOutput("t3_turn3", orient_log[2], 2);
      checkOutput("t3_turn4", orient_log[3], 0);
    end
    checkOutput("t3_linha", int'(linha), 10);
    checkOutput("t3_coluna", int'(coluna), 10);

    $display("[TB] borders");
    s = {rep("A", 9), "G", rep("A", 9), "GGG"};
    runScript(s, s.len());
    sv_head = 0; sv_left = 0;
    runScript("-", 1);
    checkOutput("t4_nw_pose", int'(linha) * 100 + int'(coluna), 101);
    checkOutput("t4_nw_head", int'(sv_head), 1);
    checkOutput("t4_nw_left", int'(sv_left), 1);
    s = {"GG", rep("A", 19), "G", rep("A", 19), "GGG"};
    runScript(s, s.len());
    sv_head = 0; sv_left = 0;
    runScript("-", 1);
    checkOutput("t4_se_pose", int'(linha) * 100 + int'(coluna), 2020);
    checkOutput("t4_se_orient", int'(orientacao), 1);
    checkOutput("t4_se_head", int'(sv_head), 1);
    checkOutput("t4_se_left", int'(sv_left), 1);

    $display("[TB] walk into a wall");
    s = {"GG", rep("A", 10), "G", rep("A", 10), "GGG"};
    runScript(s, s.len());
    map_bits[9][10] = 1;
    sv_head = 0; sv_left = 1;
    runScript("A", 5);
    checkOutput("t5_head", int'(sv_head), 1);
    checkOutput("t5_left", int'(sv_left), 0);
    checkOutput("t5_erro", int'(erro), 1);
    checkOutput("t5_fim", int'(fim), 0);
    checkOutput("t5_linha", int'(linha), 9);
    applyStimulus(3);
    repeat (10) @(negedge clock);
    checkOutput("t5_ignored_mov", int'(movimentos), 1);
    checkOutput("t5_ignored_sv", int'(sensores_validos), 0);
    checkOutput("t5_still_erro", int'(erro), 1);

    $display("[TB] reset during APPLY of move 2");
    pulseReset();
    map_bits[9][10] = 0;
    script = "";
    applyStimulus(5);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("t6_linha", int'(linha), 3);
    checkOutput("t6_coluna", int'(coluna), 4);
    checkOutput("t6_orient", int'(orientacao), 1);
    checkOutput("t6_movimentos", int'(movimentos), 0);
    checkOutput("t6_sv", int'(sensores_validos), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("t6_idle_sv", int'(sensores_validos), 0);

    $display("[TB] randomized runs");
    for (int run = 0; run < 40; run++) begin
      if (run % 10 == 0) begin
        for (int r = 1; r <= 20; r++)
          for (int c = 1; c <= 20; c++) map_bits[r][c] = ($urandom_range(0, 9) == 0);
        map_bits[SR][SC] = 0;
        pulseReset();
      end else if (m_erro || $urandom_range(0, 3) == 0) begin
        pulseReset();
      end
      script = "";
      applyStimulus($urandom_range(0, 20));
      waitIdle(1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
